// File: rtl/qiu_pkg.sv
// Shared definitions for the quantum pulse issue unit.
// Optional build macro QIU_TIMESTAMP_EN adds a release-time field to each descriptor.
package qiu_pkg;

  localparam logic [6:0] QOPCODE       = 7'b0001011;
  localparam logic [2:0] FUNCT3_QPULSE = 3'd0;
  localparam logic [2:0] FUNCT3_QDELAY = 3'd1;
  localparam logic [2:0] FUNCT3_QWAIT  = 3'd2;
  localparam logic [2:0] FUNCT3_QGETT  = 3'd3;
  localparam logic [2:0] FUNCT3_QSETT  = 3'd4;

  localparam int DELAY_W = 12;
  localparam int ADDR_W  = 32;
  localparam int TIME_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    WAIT  = 2'd2
  } qiu_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DELAY_W-1:0] delay;
`ifdef QIU_TIMESTAMP_EN
    logic [TIME_W-1:0]  tstamp;
`endif
  } qpd_entry_t;

endpackage

// File: rtl/qpd_fifo.sv
// Per-channel pulse descriptor FIFO. Head output reads as zero while empty.
// Optional build macro QIU_TIMESTAMP_EN widens the stored entry (see qiu_pkg).
module qpd_fifo
  import qiu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  qpd_entry_t entry_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output qpd_entry_t head_o
);

  localparam int PW = $clog2(DEPTH);

  qpd_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Descriptor storage, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/qpulse_issue_unit.sv
// Quantum instruction decode and multi-channel pulse descriptor issue.
// Optional build macro QIU_TIMESTAMP_EN stores release time (qtime + imm) per entry on pd_time.
//
//  state | meaning
//  IDLE  | quantum instructions execute normally
//  DELAY | QDELAY countdown running, quantum instructions stalled except QGETT
//  WAIT  | QWAIT held until all FIFOs empty and no sequencer busy
module qpulse_issue_unit
  import qiu_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  input  logic [31:0]                instr,
  input  logic [31:0]                rv1,
  output logic                       instr_ready,
  output logic [31:0]                rd_data,
  output logic                       rd_valid,
  output logic [NUM_CH-1:0]          pd_valid,
  input  logic [NUM_CH-1:0]          pd_ready,
  output logic [NUM_CH*ADDR_W-1:0]   pd_addr,
  output logic [NUM_CH*DELAY_W-1:0]  pd_delay,
  output logic [NUM_CH*TIME_W-1:0]   pd_time,
  input  logic [NUM_CH-1:0]          seq_busy,
  output logic [TIME_W-1:0]          qtime,
  output logic                       ch_err
);

  localparam int CW = $clog2(NUM_CH);

  qiu_state_e         state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [TIME_W-1:0]  qtime_q, qtime_d;
  logic [31:0]        rd_data_q;
  logic               rd_valid_q, ch_err_q;

  logic               is_q, ch_ok, wait_done;
  logic [2:0]         funct3;
  logic [4:0]         rd_field;
  logic [DELAY_W-1:0] imm;
  logic [CW-1:0]      ch_sel;
  logic               push_en, qgett, qsett, ch_err_set;
  logic [NUM_CH-1:0]  fifo_full, fifo_empty;
  qpd_entry_t         entry;
  qpd_entry_t         head [NUM_CH];
  logic               unused_rs1;

  assign is_q       = instr_valid && (instr[6:0] == QOPCODE);
  assign funct3     = instr[14:12];
  assign rd_field   = instr[11:7];
  assign imm        = instr[31:20];
  assign unused_rs1 = ^instr[19:15];
  // Full rd field is compared so out-of-range indices are caught, not aliased.
  assign ch_sel     = rd_field[CW-1:0];
  assign ch_ok      = (32'(rd_field) < NUM_CH);
  assign wait_done  = (&fifo_empty) && (seq_busy == '0);
  assign qgett      = is_q && (funct3 == FUNCT3_QGETT);

  assign entry.addr  = rv1[ADDR_W-1:0];
  assign entry.delay = imm;
`ifdef QIU_TIMESTAMP_EN
  assign entry.tstamp = qtime_q + TIME_W'(imm);
`endif

  // Next-state, stall and side-effect decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b1;
    push_en     = 1'b0;
    qsett       = 1'b0;
    ch_err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_q) begin
          case (funct3)
            FUNCT3_QPULSE: begin
              if (!ch_ok)                  ch_err_set  = 1'b1;
              else if (fifo_full[ch_sel])  instr_ready = 1'b0;
              else                         push_en     = 1'b1;
            end
            FUNCT3_QDELAY: begin
              if (imm != '0) begin
                state_d = DELAY;
                cnt_d   = imm;
              end
            end
            FUNCT3_QWAIT: begin
              instr_ready = 1'b0;
              state_d     = WAIT;
            end
            FUNCT3_QSETT: qsett = 1'b1;
            default: ;
          endcase
        end
      end
      DELAY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= DELAY_W'(1)) state_d = IDLE;
        if (is_q && !qgett) instr_ready = 1'b0;
      end
      WAIT: begin
        if (wait_done) state_d = IDLE;
        if (is_q && !qgett)
          instr_ready = (funct3 == FUNCT3_QWAIT) && wait_done;
      end
      default: state_d = IDLE;
    endcase
    // QSETT load takes priority over the free-running increment.
    qtime_d = qsett ? rv1[TIME_W-1:0] : qtime_q + 1'b1;
  end

  // Control state, timebase and QGETT result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      qtime_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ch_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      qtime_q    <= qtime_d;
      rd_valid_q <= qgett;
      if (qgett)      rd_data_q <= 32'(qtime_q);
      if (ch_err_set) ch_err_q  <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    qpd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_en && (ch_sel == CW'(c))),
      .entry_i (entry),
      .pop_i   (pd_ready[c]),
      .full_o  (fifo_full[c]),
      .empty_o (fifo_empty[c]),
      .head_o  (head[c])
    );
    assign pd_valid[c]                      = !fifo_empty[c];
    assign pd_addr[c*ADDR_W +: ADDR_W]      = head[c].addr;
    assign pd_delay[c*DELAY_W +: DELAY_W]   = head[c].delay;
`ifdef QIU_TIMESTAMP_EN
    assign pd_time[c*TIME_W +: TIME_W]      = head[c].tstamp;
`else
    assign pd_time[c*TIME_W +: TIME_W]      = '0;
`endif
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign qtime    = qtime_q;
  assign ch_err   = ch_err_q;

endmodule

// File: tb/tb_qpulse_issue_unit.sv
// Scoreboard bench for qpulse_issue_unit: directed scenarios followed by random traffic.
module tb_qpulse_issue_unit;

  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         instr_valid = 1'b0;
  logic [31:0]  instr = '0, rv1 = '0;
  logic         instr_ready;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic [3:0]   pd_valid;
  logic [3:0]   pd_ready = '0, seq_busy = '0;
  logic [127:0] pd_addr, pd_time;
  logic [47:0]  pd_delay;
  logic [31:0]  qtime;
  logic         ch_err;

  always #5 clk = ~clk;

  qpulse_issue_unit #(.NUM_CH(NCH), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr), .rv1(rv1),
    .instr_ready(instr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .pd_valid(pd_valid), .pd_ready(pd_ready), .pd_addr(pd_addr), .pd_delay(pd_delay),
    .pd_time(pd_time), .seq_busy(seq_busy), .qtime(qtime), .ch_err(ch_err)
  );

  int n_checks = 0, n_err = 0;

  // Reference model: queue occupancy, timebase, stall budget, wait flag.
  typedef struct packed { logic [31:0] a; logic [11:0] d; logic [31:0] t; } exp_t;
  exp_t        exq [NCH][$];
  logic [31:0] rdq [$];
  int          cnt [NCH];
  logic [31:0] qt;
  int          stall_left;
  bit          waiting, err;
  logic [3:0]  prdy_g = '0, busy_g = '0;
  bit          rand_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, f3, rd, 7'b0001011};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin cnt[c] = 0; exq[c].delete(); end
    rdq.delete();
    qt = '0; stall_left = 0; waiting = 0; err = 0;
  endtask

  // One clock: drive, predict, compare at negedge, advance model at posedge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] r1, output bit acc);
    bit q, rdy, done, sett, w0;
    int sl0;
    logic [2:0] f3; logic [4:0] rdf; logic [11:0] imm; logic [3:0] pv;
    exp_t e;
    if (rand_mode) begin
      prdy_g = 4'($urandom);
      busy_g = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    instr_valid = v; instr = ins; rv1 = r1; pd_ready = prdy_g; seq_busy = busy_g;
    q = v && (ins[6:0] == 7'b0001011);
    f3 = ins[14:12]; rdf = ins[11:7]; imm = ins[31:20];
    done = (busy_g == 0);
    for (int c = 0; c < NCH; c++) begin
      if (cnt[c] != 0) done = 0;
      pv[c] = (cnt[c] != 0);
    end
    if (!q || f3 == 3)       rdy = 1;
    else if (stall_left > 0) rdy = 0;
    else if (waiting)        rdy = (f3 == 2) && done;
    else if (f3 == 0)        rdy = (rdf >= NCH) || (cnt[rdf] < 8);
    else if (f3 == 2)        rdy = 0;
    else                     rdy = 1;
    @(negedge clk);
    chk("instr_ready", 32'(instr_ready), 32'(rdy));
    chk("pd_valid", 32'(pd_valid), 32'(pv));
    chk("ch_err", 32'(ch_err), 32'(err));
    chk("qtime", qtime, qt);
    @(posedge clk);
    acc = v && rdy; sett = 0; sl0 = stall_left; w0 = waiting;
    for (int c = 0; c < NCH; c++) if (prdy_g[c] && cnt[c] > 0) cnt[c]--;
    if (q && acc && f3 == 3) rdq.push_back(qt);
    if (q && acc && sl0 == 0 && !w0) begin
      case (f3)
        3'd0: if (rdf >= NCH) err = 1;
              else begin
                e.a = r1; e.d = imm; e.t = qt + 32'(imm);
                cnt[rdf]++; exq[rdf].push_back(e);
              end
        3'd1: stall_left = int'(imm);
        3'd4: sett = 1;
        default: ;
      endcase
    end
    if (sl0 > 0) stall_left = sl0 - 1;
    if (w0 && done) waiting = 0;
    else if (!w0 && sl0 == 0 && q && f3 == 2) waiting = 1;
    qt = sett ? r1 : qt + 1;
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, output int stalls);
    bit acc;
    stalls = 0;
    cycle(1'b1, ins, r1, acc);
    while (!acc && stalls < 300) begin
      stalls++;
      cycle(1'b1, ins, r1, acc);
    end
    if (!acc) begin
      n_checks++; n_err++;
      $display("FAIL issue_timeout: instr %h not accepted, required acceptance", ins);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, acc);
  endtask

  task automatic do_reset();
    instr_valid = 0; pd_ready = '0; seq_busy = '0;
    reset = 1;
    #2;
    chk("rst_pd_valid", 32'(pd_valid), 0);
    chk("rst_ch_err", 32'(ch_err), 0);
    chk("rst_qtime", qtime, 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    model_clear();
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
  endtask

  // Monitor: pops expected results whenever the DUT presents them.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) begin
        if (rdq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL rd_valid: unexpected strobe data %h, required none", rd_data);
        end else chk("rd_data", rd_data, rdq.pop_front());
      end
      for (int c = 0; c < NCH; c++) begin
        if (pd_valid[c] && pd_ready[c]) begin
          if (exq[c].size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL pd_pop ch%0d: unexpected descriptor addr %h, required none", c, pd_addr[c*32 +: 32]);
          end else begin
            exp_t e;
            e = exq[c].pop_front();
            chk("pd_addr", pd_addr[c*32 +: 32], e.a);
            chk("pd_delay", 32'(pd_delay[c*12 +: 12]), 32'(e.d));
`ifdef QIU_TIMESTAMP_EN
            chk("pd_time", pd_time[c*32 +: 32], e.t);
`else
            chk("pd_time_zero", pd_time[c*32 +: 32], 0);
`endif
          end
        end
      end
    end
  end

  initial begin
    int s;
    bit acc, have, v;
    int held;
    logic [31:0] ins, r1;
    int k;

    #1;
    do_reset();

    // Single push appears on its channel next cycle.
    prdy_g = '0; busy_g = '0;
    issue(enc(3'd0, 5'd2, 12'd5), 32'h100, s);
    chk("t1_pd_valid", 32'(pd_valid), 32'h4);
    chk("t1_addr", pd_addr[64 +: 32], 32'h100);
    chk("t1_delay", 32'(pd_delay[24 +: 12]), 5);

    // Fill channel 0, ninth push stalls until a pop has registered.
    for (int i = 0; i < 8; i++) begin
      issue(enc(3'd0, 5'd0, 12'(i)), 32'h200 + 32'(i), s);
      chk("t2_fill_stall", s, 0);
    end
    cycle(1'b1, enc(3'd0, 5'd0, 12'd8), 32'h208, acc); chk("t2_full_hold", 32'(acc), 0);
    cycle(1'b1, enc(3'd0, 5'd0, 12'd8), 32'h208, acc); chk("t2_full_hold", 32'(acc), 0);
    prdy_g = 4'h1;
    cycle(1'b1, enc(3'd0, 5'd0, 12'd8), 32'h208, acc); chk("t2_pop_same_cycle", 32'(acc), 0);
    prdy_g = 4'h0;
    cycle(1'b1, enc(3'd0, 5'd0, 12'd8), 32'h208, acc); chk("t2_after_pop", 32'(acc), 1);

    // QDELAY stall length.
    issue(enc(3'd1, 5'd0, 12'd3), 32'h0, s);
    issue(enc(3'd0, 5'd3, 12'd7), 32'h300, s);
    chk("t3_delay3_stalls", s, 3);
    issue(enc(3'd1, 5'd0, 12'd0), 32'h0, s);
    issue(enc(3'd0, 5'd3, 12'd9), 32'h301, s);
    chk("t3_delay0_stalls", s, 0);

    prdy_g = 4'hF;
    idle(12);

    // QWAIT held by pending entries and busy sequencer.
    prdy_g = 4'h0; busy_g = 4'h2;
    issue(enc(3'd0, 5'd1, 12'd1), 32'h400, s);
    issue(enc(3'd0, 5'd1, 12'd2), 32'h404, s);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, enc(3'd2, 5'd0, 12'd0), 32'h0, acc);
      chk("t4_qwait_hold", 32'(acc), 0);
    end
    prdy_g = 4'hF; busy_g = 4'h0;
    issue(enc(3'd2, 5'd0, 12'd0), 32'h0, s);
    chk("t4_release_stalls", s, 2);

    // Timebase load and wrap.
    issue(enc(3'd4, 5'd0, 12'd0), 32'hFFFF_FFFF, s);
    issue(enc(3'd3, 5'd0, 12'd0), 32'h0, s);
    chk("t5_rd_valid", 32'(rd_valid), 1);
    chk("t5_rd_max", rd_data, 32'hFFFF_FFFF);
    issue(enc(3'd3, 5'd0, 12'd0), 32'h0, s);
    chk("t5_rd_wrap", rd_data, 0);

    // Bad channel, then reset while waiting.
    prdy_g = 4'h0;
    issue(enc(3'd0, 5'd5, 12'd1), 32'h500, s);
    chk("t6_ch_err", 32'(ch_err), 1);
    busy_g = 4'h2;
    issue(enc(3'd0, 5'd1, 12'd3), 32'h600, s);
    cycle(1'b1, enc(3'd2, 5'd0, 12'd0), 32'h0, acc); chk("t6_wait", 32'(acc), 0);
    cycle(1'b1, enc(3'd2, 5'd0, 12'd0), 32'h0, acc); chk("t6_wait", 32'(acc), 0);
    do_reset();
    busy_g = 4'h0;
    issue(enc(3'd0, 5'd1, 12'd4), 32'h700, s);
    chk("t6_post_reset_stalls", s, 0);

    // Random traffic.
    rand_mode = 1; have = 0; held = 0; ins = '0; r1 = '0; v = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!have) begin
        k = $urandom_range(0, 19);
        r1 = $urandom;
        if (k < 8)
          ins = enc(3'd0, ($urandom_range(0, 39) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3)),
                    12'($urandom));
        else if (k < 10) ins = enc(3'd1, 5'd0, 12'($urandom_range(0, 6)));
        else if (k < 11) ins = enc(3'd2, 5'd0, 12'd0);
        else if (k < 13) ins = enc(3'd3, 5'($urandom), 12'($urandom));
        else if (k < 14) begin
          ins = enc(3'd4, 5'd0, 12'd0);
          if ($urandom_range(0, 1) == 0) r1 = 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
        end
        else if (k < 16) ins = enc(3'($urandom_range(5, 7)), 5'($urandom), 12'($urandom));
        else begin
          ins = $urandom;
          ins[6:0] = 7'b0110011;
        end
        v = ($urandom_range(0, 3) != 0);
        held = 0;
      end
      cycle(v, ins, r1, acc);
      if (v && !acc) begin
        have = 1; held++;
        if (held > 300) begin
          n_checks++; n_err++;
          $display("FAIL stall_timeout: instr %h held %0d cycles, required acceptance", ins, held);
          have = 0;
        end
      end else have = 0;
    end

    rand_mode = 0; prdy_g = 4'hF; busy_g = 4'h0;
    idle(20);
    chk("rdq_left", 32'(rdq.size()), 0);
    for (int c = 0; c < NCH; c++) chk("exq_left", 32'(exq[c].size()), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
